// File: rtl/register_stack_pkg.sv
// Shared definitions for the register stack: opcode encoding and opcode width.
package register_stack_pkg;

    localparam int OP_W = 3;

    // Opcodes 6 and 7 are unassigned and act as NOP.
    typedef enum logic [OP_W-1:0] {
        OP_NOP      = 3'd0,
        OP_PUSH     = 3'd1,
        OP_REPLACE2 = 3'd2,
        OP_POP      = 3'd3,
        OP_POP2     = 3'd4,
        OP_SWAP     = 3'd5
    } stack_op_e;

endpackage

// File: rtl/register_stack.sv
// Register stack: a shift-register array of DEPTH entries with s[0] as top,
// plus an occupancy count. The top two entries are exposed as a and b so an
// external ALU can compute a result and write it back with REPLACE2.
// Entries vacated by pops or binary-op replacement always fill with zero,
// so underflow is silent and reads back as 0.
module register_stack
    import register_stack_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [OP_W-1:0]  stackOP,
    input  logic [WIDTH-1:0] w,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             empty,
    output logic             full
);

    localparam int            CW       = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] TWO      = CW'(2);

    logic [WIDTH-1:0] s      [DEPTH];
    logic [WIDTH-1:0] s_next [DEPTH];
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;

    // Next-state of the entry array and count for the sampled opcode.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            s_next[i] = s[i];
        end
        count_next = count;
        case (stackOP)
            OP_PUSH: begin
                // When full, the bottom entry falls off the end.
                s_next[0] = w;
                for (int i = 1; i < DEPTH; i++) begin
                    s_next[i] = s[i-1];
                end
                if (count != FULL_CNT) begin
                    count_next = count + ONE;
                end
            end
            OP_REPLACE2: begin
                // Consumes the two operands and leaves the result on top.
                s_next[0] = w;
                for (int i = 1; i < DEPTH - 1; i++) begin
                    s_next[i] = s[i+1];
                end
                s_next[DEPTH-1] = '0;
                count_next = (count > ONE) ? count - ONE : ONE;
            end
            OP_POP: begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    s_next[i] = s[i+1];
                end
                s_next[DEPTH-1] = '0;
                count_next = (count != '0) ? count - ONE : '0;
            end
            OP_POP2: begin
                for (int i = 0; i < DEPTH - 2; i++) begin
                    s_next[i] = s[i+2];
                end
                s_next[DEPTH-2] = '0;
                s_next[DEPTH-1] = '0;
                count_next = (count >= TWO) ? count - TWO : '0;
            end
            OP_SWAP: begin
                s_next[0] = s[1];
                s_next[1] = s[0];
            end
            default: begin
                // NOP and unassigned opcodes hold state.
            end
        endcase
    end

    // State register; reset clears every entry and the count immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                s[i] <= '0;
            end
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                s[i] <= s_next[i];
            end
            count <= count_next;
        end
    end

    assign a     = s[0];
    assign b     = s[1];
    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

endmodule

// File: tb/tb_register_stack.sv
// Testbench for register_stack: directed scenarios followed by random
// opcode streams, checked against a queue-based reference model.
module tb_register_stack;

    localparam int DEPTH = 16;
    localparam int WIDTH = 16;

    logic             CLK;
    logic             RST;
    logic [2:0]       stackOP;
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             empty;
    logic             full;

    int checks = 0;
    int errors = 0;

    // Reference model: all DEPTH entries (index 0 = top) plus occupancy.
    logic [WIDTH-1:0] exp_q[$];
    int               exp_cnt;

    register_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .stackOP (stackOP),
        .w       (w),
        .a       (a),
        .b       (b),
        .empty   (empty),
        .full    (full)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back('0);
        exp_cnt = 0;
    endtask

    task automatic model_apply(input logic [2:0] op, input logic [WIDTH-1:0] wv);
        logic [WIDTH-1:0] t;
        case (op)
            3'd1: begin
                exp_q.push_front(wv);
                t = exp_q.pop_back();
                exp_cnt = (exp_cnt + 1 > DEPTH) ? DEPTH : exp_cnt + 1;
            end
            3'd2: begin
                t = exp_q.pop_front();
                t = exp_q.pop_front();
                exp_q.push_back('0);
                exp_q.push_front(wv);
                exp_cnt = (exp_cnt - 1 < 1) ? 1 : exp_cnt - 1;
            end
            3'd3: begin
                t = exp_q.pop_front();
                exp_q.push_back('0);
                exp_cnt = (exp_cnt - 1 < 0) ? 0 : exp_cnt - 1;
            end
            3'd4: begin
                t = exp_q.pop_front();
                t = exp_q.pop_front();
                exp_q.push_back('0);
                exp_q.push_back('0);
                exp_cnt = (exp_cnt - 2 < 0) ? 0 : exp_cnt - 2;
            end
            3'd5: begin
                t = exp_q[0];
                exp_q[0] = exp_q[1];
                exp_q[1] = t;
            end
            default: ;
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".a"}, 32'(a), 32'(exp_q[0]));
        chk({tag, ".b"}, 32'(b), 32'(exp_q[1]));
        chk({tag, ".empty"}, 32'(empty), 32'(exp_cnt == 0));
        chk({tag, ".full"}, 32'(full), 32'(exp_cnt == DEPTH));
    endtask

    // Drive one opcode for exactly one rising edge, then compare with model.
    task automatic do_op(input logic [2:0] op, input logic [WIDTH-1:0] wv, input string tag);
        @(negedge CLK);
        stackOP = op;
        w       = wv;
        @(posedge CLK);
        #1;
        model_apply(op, wv);
        stackOP = 3'd0;
        w       = $urandom;
        chk_model(tag);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [2:0]       op;
        logic [WIDTH-1:0] wv;

        RST     = 1'b0;
        stackOP = 3'd0;
        w       = '0;
        model_reset();

        // Reset state, observed before any clock edge.
        #1 RST = 1'b1;
        #1;
        chk("rst.a", 32'(a), 32'h0);
        chk("rst.b", 32'(b), 32'h0);
        chk("rst.empty", 32'(empty), 32'h1);
        chk("rst.full", 32'(full), 32'h0);
        // An opcode present while reset is held must not take effect.
        stackOP = 3'd1;
        w       = 16'h1234;
        @(posedge CLK);
        #1;
        chk("rst_hold.empty", 32'(empty), 32'h1);
        chk("rst_hold.a", 32'(a), 32'h0);
        @(negedge CLK);
        RST     = 1'b0;
        stackOP = 3'd0;

        // PUSH 1, PUSH 2, REPLACE2 with compare result 1.
        do_op(3'd1, 16'd1, "p1");
        do_op(3'd1, 16'd2, "p2");
        chk("p2.a_const", 32'(a), 32'd2);
        chk("p2.b_const", 32'(b), 32'd1);
        do_op(3'd2, 16'd1, "repl_lt");
        chk("repl_lt.a_const", 32'(a), 32'd1);
        chk("repl_lt.b_const", 32'(b), 32'd0);
        chk("repl_lt.empty_const", 32'(empty), 32'd0);

        // PUSH 5, PUSH 9, SWAP, POP, POP2 from count 1.
        do_reset();
        do_op(3'd1, 16'd5, "p5");
        do_op(3'd1, 16'd9, "p9");
        do_op(3'd5, 16'hBEEF, "swap");
        chk("swap.a_const", 32'(a), 32'd5);
        chk("swap.b_const", 32'(b), 32'd9);
        do_op(3'd3, 16'hBEEF, "pop");
        chk("pop.a_const", 32'(a), 32'd9);
        chk("pop.b_const", 32'(b), 32'd0);
        do_op(3'd4, 16'hBEEF, "pop2_under");
        chk("pop2_under.empty_const", 32'(empty), 32'd1);
        chk("pop2_under.a_const", 32'(a), 32'd0);

        // Fill to DEPTH, overflow push drops the oldest entry.
        do_reset();
        for (int i = 1; i <= DEPTH; i++) do_op(3'd1, WIDTH'(i), "fill");
        chk("fill.full_const", 32'(full), 32'd1);
        chk("fill.a_const", 32'(a), 32'(DEPTH));
        do_op(3'd1, 16'hFFFF, "overflow");
        chk("overflow.a_const", 32'(a), 32'hFFFF);
        chk("overflow.full_const", 32'(full), 32'd1);
        for (int i = 0; i < DEPTH - 1; i++) do_op(3'd3, 16'h0, "drain");
        chk("drain.last_a_const", 32'(a), 32'd2);
        chk("drain.not_empty_const", 32'(empty), 32'd0);
        do_op(3'd3, 16'h0, "drain_end");
        chk("drain_end.empty_const", 32'(empty), 32'd1);

        // Add via REPLACE2, then unassigned opcode 6 holds.
        do_reset();
        do_op(3'd1, 16'd3, "p3");
        do_op(3'd1, 16'd4, "p4");
        do_op(3'd2, 16'd7, "add");
        do_op(3'd6, 16'h5555, "op6");
        do_op(3'd7, 16'hAAAA, "op7");
        chk("op6.a_const", 32'(a), 32'd7);
        chk("op6.b_const", 32'(b), 32'd0);
        do_op(3'd3, 16'h0, "op6_pop");
        chk("op6_pop.empty_const", 32'(empty), 32'd1);

        // Asynchronous reset between edges with data present.
        do_op(3'd1, 16'h00A1, "pa");
        do_op(3'd1, 16'h00B2, "pb");
        @(posedge CLK);
        #3 RST = 1'b1;
        #1;
        chk("async.a", 32'(a), 32'h0);
        chk("async.b", 32'(b), 32'h0);
        chk("async.empty", 32'(empty), 32'h1);
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
        do_op(3'd1, 16'h0042, "post_rst");

        // Random stream, biased toward PUSH so full is reached.
        for (int n = 0; n < 600; n++) begin
            op = ($urandom_range(0, 3) == 0) ? 3'd1 : 3'($urandom_range(0, 7));
            wv = WIDTH'($urandom);
            do_op(op, wv, "rand");
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
                chk_model("rand_rst");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
